mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencer, sitting beside the ALU in the EX stage.
- Accepts one MIPS mult/multu/div/divu/mthi/mtlo operation per request.
- Models the fixed iterative latency with a countdown counter, and owns the HI/LO architectural registers.
- Exposes busy/start status so the hazard unit can stall mfhi/mflo/md-class instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- operand1  input  32  rs value (forwarded)
- operand2  input  32  rt value (forwarded)
- operation  input  `MDUOP_SIZE  operation code; MDUOP_NONE when EX holds no md instruction
- hi  output  32  HI register (mfhi read path, combinational from register)
- lo  output  32  LO register (mflo read path)
- busy  output  1  operation in flight
- start  output  1  combinational: operation is MULT/MULTU/DIV/DIVU and busy==0 (accepted this cycle)

Behaviour:
- Reset (sync, highest priority):
  - hi=0, lo=0, busy=0, counter=0, pending result=0.
  - Reset mid-operation aborts; no HI/LO commit.
- Acceptance:
  - An operation is accepted only in a cycle with busy==0.
  - Any non-NONE operation presented while busy==1 is ignored; no state change.
  - The hazard unit guarantees this does not occur; the bench still checks it.
- MTHI/MTLO (busy==0): hi<=operand1 (or lo<=operand1) at the clock edge. Zero busy cycles; start stays 0.
- Start timing (MULT/MULTU/DIV/DIVU, busy==0, in cycle T):
  - start=1 in cycle T.
  - At the edge ending T: result captured into internal pend_hi/pend_lo, counter<=N (MULT_CYCLES or DIV_CYCLES), busy<=1.
- Busy window:
  - busy=1 in cycles T+1 .. T+N.
  - Counter decrements each cycle; busy = (counter != 0).
- Commit: at the edge ending cycle T+N, hi<=pend_hi, lo<=pend_lo. New values are visible and busy=0 in cycle T+N+1.
  - HI/LO hold their old values throughout the busy window (mfhi during busy must be stalled externally).
- Arithmetic:
  - MULT: 64-bit signed product {hi,lo} = $signed(op1)*$signed(op2).
  - MULTU: unsigned product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (operand2==0): the op still occupies DIV_CYCLES busy cycles, but HI/LO are left unchanged at commit (a commit-enable flag is captured at start).
- Back-to-back: a new start is legal in cycle T+N+1 (first cycle with busy==0).
- Stall contract for the hazard unit: stall D when the D instruction is md-class (mult/div/mfhi/mflo/mthi/mtlo) and (start | busy).

Decomposition:
- macros.v additions:
  - `MDUOP_SIZE (3)
  - `MDUOP_NONE, `MDUOP_MULT, `MDUOP_MULTU, `MDUOP_DIV, `MDUOP_DIVU, `MDUOP_MTHI, `MDUOP_MTLO
  - `MULT_CYCLES, `DIV_CYCLES defaults
- One sub-module: mdu_compute, purely combinational. Takes operand1, operand2 and the op; returns 64-bit {res_hi,res_lo} plus a valid flag (0 on divide by zero).
- mdu_ctrl holds the counter, pending registers and HI/LO.

Test Plan:
- Reset, then MTHI 0x12345678 and next cycle MTLO 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; busy never asserted.
- MULT op1=0xFFFFFFFF op2=0x00000002 in cycle T:
  - start=1 at T; busy=1 exactly in T+1..T+5.
  - In T+6: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV op1=0xFFFFFFF9 (-7) op2=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU op1=7 op2=2 -> lo=3, hi=1.
- Preload hi=0xAAAA, lo=0x5555; DIV op2=0 -> busy for 10 cycles, then hi=0xAAAA and lo=0x5555 unchanged.
- MULT started; during busy apply MTHI 0xDEAD and a second MULT -> both ignored; final hi/lo are the first MULT's result; busy drops after exactly 5 cycles.
- DIV started; assert reset in busy cycle 4 -> next cycle busy=0, hi=lo=0; no later commit occurs.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies
// and a helper that classifies an op as one that occupies the iterative datapath.
// Latency: n/a (definitions only). Backpressure: n/a.
package mdu_ctrl_pkg;

   localparam int MDUOP_SIZE = 3;

   typedef enum logic [MDUOP_SIZE-1:0] {
      MDUOP_NONE  = 3'd0,
      MDUOP_MULT  = 3'd1,
      MDUOP_MULTU = 3'd2,
      MDUOP_DIV   = 3'd3,
      MDUOP_DIVU  = 3'd4,
      MDUOP_MTHI  = 3'd5,
      MDUOP_MTLO  = 3'd6
   } mduop_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // True for ops that start a multi-cycle busy window (mult/multu/div/divu).
   function automatic logic is_start_op(input logic [MDUOP_SIZE-1:0] op);
      return (op == MDUOP_MULT) || (op == MDUOP_MULTU) ||
             (op == MDUOP_DIV)  || (op == MDUOP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_compute.sv
// mdu_compute: combinational result generator for mult/multu/div/divu.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
// Ports: operand1/operand2 (rs/rt), operation; res_hi/res_lo result halves,
//        res_valid = 0 when a divide has a zero divisor (HI/LO must not change).
module mdu_compute
   import mdu_ctrl_pkg::*;
(
   input  logic [31:0]            operand1,
   input  logic [31:0]            operand2,
   input  logic [MDUOP_SIZE-1:0]  operation,
   output logic [31:0]            res_hi,
   output logic [31:0]            res_lo,
   output logic                   res_valid
);

   logic        div_by_zero;
   logic [31:0] divisor;
   logic [63:0] sprod;
   logic [63:0] uprod;
   logic [31:0] squot;
   logic [31:0] srem;
   logic [31:0] uquot;
   logic [31:0] urem;

   assign div_by_zero = (operand2 == 32'd0);
   // Keep the dividers away from a zero divisor; the result is discarded anyway.
   assign divisor     = div_by_zero ? 32'd1 : operand2;

   assign sprod = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
   assign uprod = {32'd0, operand1} * {32'd0, operand2};
   // SV signed / and % truncate toward zero, remainder takes the dividend's sign.
   assign squot = $signed(operand1) / $signed(divisor);
   assign srem  = $signed(operand1) % $signed(divisor);
   assign uquot = operand1 / divisor;
   assign urem  = operand1 % divisor;

   always_comb begin
      res_hi    = 32'd0;
      res_lo    = 32'd0;
      res_valid = 1'b0;
      case (operation)
         MDUOP_MULT: begin
            res_hi    = sprod[63:32];
            res_lo    = sprod[31:0];
            res_valid = 1'b1;
         end
         MDUOP_MULTU: begin
            res_hi    = uprod[63:32];
            res_lo    = uprod[31:0];
            res_valid = 1'b1;
         end
         MDUOP_DIV: begin
            res_hi    = srem;
            res_lo    = squot;
            res_valid = !div_by_zero;
         end
         MDUOP_DIVU: begin
            res_hi    = urem;
            res_lo    = uquot;
            res_valid = !div_by_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage multiply/divide sequencer owning the HI/LO registers.
// Latency: mthi/mtlo 1 edge; mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles, HI/LO visible next.
// Backpressure: none; ops presented while busy are dropped (hazard unit stalls on start|busy).
// Ports: clk, reset (sync, active-high); operand1/operand2/operation request;
//        hi/lo architectural registers; busy = op in flight; start = op accepted this cycle.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            operand1,
   input  logic [31:0]            operand2,
   input  logic [MDUOP_SIZE-1:0]  operation,
   output logic [31:0]            hi,
   output logic [31:0]            lo,
   output logic                   busy,
   output logic                   start
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] counter;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_vld;   // commit enable; cleared for divide by zero
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_valid;
   logic             is_mult;

   mdu_compute u_compute (
      .operand1  (operand1),
      .operand2  (operand2),
      .operation (operation),
      .res_hi    (res_hi),
      .res_lo    (res_lo),
      .res_valid (res_valid)
   );

   assign busy    = (counter != '0);
   assign start   = is_start_op(operation) && !busy;
   assign is_mult = (operation == MDUOP_MULT) || (operation == MDUOP_MULTU);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi       <= 32'd0;
         lo       <= 32'd0;
         counter  <= '0;
         pend_hi  <= 32'd0;
         pend_lo  <= 32'd0;
         pend_vld <= 1'b0;
      end else if (busy) begin
         // Any request arriving here is dropped; only the countdown advances.
         counter <= counter - CNT_W'(1);
         if (counter == CNT_W'(1) && pend_vld) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end else begin
         case (operation)
            MDUOP_MTHI: hi <= operand1;
            MDUOP_MTLO: lo <= operand1;
            MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU: begin
               // Result is computed now and held until the latency has elapsed.
               pend_hi  <= res_hi;
               pend_lo  <= res_lo;
               pend_vld <= res_valid;
               counter  <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] operand1, operand2;
   logic [2:0]  operation;
   logic [31:0] hi, lo;
   logic        busy, start;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .operand1(operand1), .operand2(operand2),
      .operation(operation), .hi(hi), .lo(lo), .busy(busy), .start(start)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;
   exp_t sbq[$];

   // Architectural reference: HI/LO, remaining latency, pending result.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   bit          m_pok;
   int          m_left;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Results from plain 64-bit arithmetic on magnitudes.
   task automatic ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl, output bit ok);
      longint      sa, sb, ma, mb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      rh = 32'd0; rl = 32'd0; ok = 1'b1;
      case (op)
         MDUOP_MULT:  begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
         MDUOP_MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
         MDUOP_DIV: begin
            if (b == 32'd0) ok = 1'b0;
            else begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q  = ma / mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               r  = sa - q * sb;
               p = 64'(q); rl = p[31:0];
               p = 64'(r); rh = p[31:0];
            end
         end
         default: begin // DIVU
            if (b == 32'd0) ok = 1'b0;
            else begin
               ma = longint'({32'd0, a});
               mb = longint'({32'd0, b});
               q  = ma / mb;
               r  = ma - q * mb;
               p = 64'(q); rl = p[31:0];
               p = 64'(r); rh = p[31:0];
            end
         end
      endcase
   endtask

   // Monitor: on each busy->idle transition, pop the expected commit.
   int busy_cnt  = 0;
   bit prev_busy = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_cnt  = 0;
         prev_busy = 0;
      end else begin
         if (busy) busy_cnt++;
         else if (prev_busy) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_commit: got busy window of %0d cycles, required none", busy_cnt);
            end else begin
               e = sbq.pop_front();
               chk("commit_hi", 64'(hi), 64'(e.hi));
               chk("commit_lo", 64'(lo), 64'(e.lo));
               chk("busy_len", 64'(busy_cnt), 64'(e.cycles));
            end
            busy_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
   task automatic cyc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] rh, rl;
      bit          ok;
      exp_t        e;
      operation = op; operand1 = a; operand2 = b;
      @(negedge clk);
      chk("start", 64'(start), 64'((m_left == 0) && is_start_op(op)));
      chk("busy",  64'(busy),  64'(m_left > 0));
      chk("hi",    64'(hi),    64'(m_hi));
      chk("lo",    64'(lo),    64'(m_lo));
      @(posedge clk);
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (op == MDUOP_MTHI) m_hi = a;
      else if (op == MDUOP_MTLO) m_lo = a;
      else if (is_start_op(op)) begin
         ref_result(op, a, b, rh, rl, ok);
         m_phi = rh; m_plo = rl; m_pok = ok;
         m_left = (op == MDUOP_MULT || op == MDUOP_MULTU) ? MC : DC;
         e.hi = ok ? rh : m_hi;
         e.lo = ok ? rl : m_lo;
         e.cycles = m_left;
         sbq.push_back(e);
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(MDUOP_NONE, 32'd0, 32'd0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      operation = MDUOP_NONE; operand1 = 32'd0; operand2 = 32'd0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_pok = 0; m_left = 0;
      sbq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          r;
      reset = 1'b1; operation = MDUOP_NONE; operand1 = 32'd0; operand2 = 32'd0;
      do_reset(3);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_lo", 64'(lo), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

      // mthi / mtlo
      cyc(MDUOP_MTHI, 32'h12345678, 32'd0);
      cyc(MDUOP_MTLO, 32'h9ABCDEF0, 32'd0);
      idle(1);
      chk("mthi_val", 64'(hi), 64'h12345678);
      chk("mtlo_val", 64'(lo), 64'h9ABCDEF0);

      // mult / multu
      cyc(MDUOP_MULT, 32'hFFFFFFFF, 32'h2);
      idle(MC + 1);
      chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
      chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
      cyc(MDUOP_MULTU, 32'hFFFFFFFF, 32'h2);
      idle(MC + 1);
      chk("multu_hi", 64'(hi), 64'h1);
      chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

      // div / divu
      cyc(MDUOP_DIV, 32'hFFFFFFF9, 32'h2);
      idle(DC + 1);
      chk("div_hi", 64'(hi), 64'hFFFFFFFF);
      chk("div_lo", 64'(lo), 64'hFFFFFFFD);
      cyc(MDUOP_DIVU, 32'd7, 32'd2);
      idle(DC + 1);
      chk("divu_hi", 64'(hi), 64'd1);
      chk("divu_lo", 64'(lo), 64'd3);

      // divide by zero leaves HI/LO alone
      cyc(MDUOP_MTHI, 32'hAAAA, 32'd0);
      cyc(MDUOP_MTLO, 32'h5555, 32'd0);
      cyc(MDUOP_DIV, 32'd100, 32'd0);
      idle(DC + 1);
      chk("div0_hi", 64'(hi), 64'hAAAA);
      chk("div0_lo", 64'(lo), 64'h5555);

      // requests during busy are ignored; back-to-back start right after
      cyc(MDUOP_MULT, 32'd3, 32'd4);
      idle(1);
      cyc(MDUOP_MTHI, 32'hDEAD, 32'd0);
      cyc(MDUOP_MULT, 32'd100, 32'd100);
      idle(MC - 3);
      cyc(MDUOP_MULTU, 32'd6, 32'd7);
      chk("ignore_hi", 64'(hi), 64'd0);
      chk("ignore_lo", 64'(lo), 64'd12);
      idle(MC + 1);
      chk("b2b_lo", 64'(lo), 64'd42);

      // reset in busy cycle 4 aborts the divide
      cyc(MDUOP_DIV, 32'd1000, 32'd7);
      idle(3);
      do_reset(1);
      idle(DC + 4);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);

      // randomized traffic, including ops issued while busy
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 11);
         op = (r > 6) ? MDUOP_NONE : 3'(r);
         a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         b  = ($urandom_range(0, 6) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 4) == 0) b = 32'hFFFFFFFF;
         if (op == MDUOP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         cyc(op, a, b);
      end
      idle(DC + 2);
      chk("queue_empty", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
